multicycle_control_unit: RTL and testbench

//  Sequenced RV32I control for the multi-cycle core. Replaces the combinational control unit:

---
 rtl/rv32i_ctrl_pkg.sv | 57 +++++
 rtl/rv32i_alu_decoder.sv | 58 +++++
 rtl/multicycle_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Encodings shared by the multi-cycle control unit, the datapath and the ALU.
// Opcodes, FSM states, and the select/operation fields the control unit drives.
package rv32i_ctrl_pkg;

   localparam int unsigned OPCODE_W  = 7;
   localparam int unsigned FUN3_W    = 3;
   localparam int unsigned ALU_W     = 4;
   localparam int unsigned IMM_SEL_W = 3;
   localparam int unsigned WB_SEL_W  = 2;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
   } state_t;

   typedef enum logic [IMM_SEL_W-1:0] {
      IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
   } imm_sel_t;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
      ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
      ALU_OR   = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10
   } alu_op_t;

   typedef enum logic [WB_SEL_W-1:0] {
      WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2
   } wb_sel_t;

   // fun7 only distinguishes SUB on register ops; SRA/SRL split applies to both forms.
   function automatic alu_op_t alu_from_fun3(input logic [FUN3_W-1:0] fun3,
                                             input logic fun7,
                                             input logic is_reg);
      alu_op_t op;
      case (fun3)
         3'b000: if (is_reg && fun7) op = ALU_SUB; else op = ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: if (fun7) op = ALU_SRA; else op = ALU_SRL;
         3'b110: op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational decode of latched instruction fields into ALU op, immediate
// format and operand selects; also flags opcodes the core does not implement.
module rv32i_alu_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic [FUN3_W-1:0]    fun3,
   input  logic                 fun7,
   output logic [ALU_W-1:0]     alu_control,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic                 operand_a,
   output logic                 operand_b,
   output logic                 legal
);

   always_comb begin
      alu_control = ALU_ADD;
      imm_sel     = IMM_I;
      operand_a   = 1'b0;
      operand_b   = 1'b0;
      legal       = 1'b1;
      case (opcode)
         OP_REG:    alu_control = alu_from_fun3(fun3, fun7, 1'b1);
         OP_IMM: begin
            operand_b   = 1'b1;
            alu_control = alu_from_fun3(fun3, fun7, 1'b0);
         end
         OP_LOAD:   operand_b = 1'b1;
         OP_STORE: begin
            imm_sel   = IMM_S;
            operand_b = 1'b1;
         end
         OP_BRANCH: begin
            imm_sel   = IMM_B;
            operand_a = 1'b1;
            operand_b = 1'b1;
         end
         OP_LUI: begin
            imm_sel     = IMM_U;
            operand_b   = 1'b1;
            alu_control = ALU_PASS_B;
         end
         OP_AUIPC: begin
            imm_sel   = IMM_U;
            operand_a = 1'b1;
            operand_b = 1'b1;
         end
         OP_JAL: begin
            imm_sel   = IMM_J;
            operand_a = 1'b1;
            operand_b = 1'b1;
         end
         OP_JALR:   operand_b = 1'b1;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Sequenced RV32I control: FETCH/DECODE/EXEC/MEM/WB FSM with imem/dmem
// handshakes, a wait-state timeout and a sticky trap for illegal opcodes.
module multicycle_control_unit
   import rv32i_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic [FUN3_W-1:0]    fun3,
   input  logic                 fun7,
   input  logic                 br_taken,
   output logic                 imem_req,
   input  logic                 imem_ack,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ack,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 next_sel,
   output logic                 reg_write,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic                 operand_a,
   output logic                 operand_b,
   output logic [WB_SEL_W-1:0]  mem_to_reg,
   output logic [ALU_W-1:0]     alu_control,
   output logic                 illegal,
   output logic                 fault
);

   localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [OPCODE_W-1:0]   op_q, op_d;
   logic [FUN3_W-1:0]     f3_q, f3_d;
   logic                  f7_q, f7_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  illegal_q, illegal_d, fault_q, fault_d;

   logic [ALU_W-1:0]      dec_alu;
   logic [IMM_SEL_W-1:0]  dec_imm;
   logic                  dec_a, dec_b, dec_legal;
   logic                  is_load, is_store, is_branch, is_jump;

   rv32i_alu_decoder u_alu_decoder (
      .opcode      (op_q),
      .fun3        (f3_q),
      .fun7        (f7_q),
      .alu_control (dec_alu),
      .imm_sel     (dec_imm),
      .operand_a   (dec_a),
      .operand_b   (dec_b),
      .legal       (dec_legal)
   );

   assign is_load   = (op_q == OP_LOAD);
   assign is_store  = (op_q == OP_STORE);
   assign is_branch = (op_q == OP_BRANCH);
   assign is_jump   = (op_q == OP_JAL) || (op_q == OP_JALR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         op_q      <= '0;
         f3_q      <= '0;
         f7_q      <= 1'b0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         f3_q      <= f3_d;
         f7_q      <= f7_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         fault_q   <= fault_d;
      end
   end

   // Next state; the wait counter restarts whenever FETCH or MEM is entered.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      f3_d      = f3_q;
      f7_d      = f7_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      fault_d   = fault_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               op_d    = opcode;
               f3_d    = fun3;
               f7_d    = fun7;
               state_d = ST_DECODE;
            end else if (cnt_q == WAIT_LAST) begin
               fault_d = 1'b1;
               state_d = ST_TRAP;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         ST_DECODE: begin
            if (dec_legal) begin
               state_d = ST_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = ST_TRAP;
            end
         end
         ST_EXEC: begin
            cnt_d = '0;
            if (is_branch)                state_d = ST_FETCH;
            else if (is_load || is_store) state_d = ST_MEM;
            else                          state_d = ST_WB;
         end
         ST_MEM: begin
            if (dmem_ack) begin
               cnt_d   = '0;
               state_d = is_store ? ST_FETCH : ST_WB;
            end else if (cnt_q == WAIT_LAST) begin
               fault_d = 1'b1;
               state_d = ST_TRAP;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         ST_WB: begin
            cnt_d   = '0;
            state_d = ST_FETCH;
         end
         default: state_d = ST_TRAP;
      endcase
   end

   // Per-state control; rst gates FETCH so nothing is requested while held in reset.
   always_comb begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      next_sel    = 1'b0;
      reg_write   = 1'b0;
      imm_sel     = '0;
      operand_a   = 1'b0;
      operand_b   = 1'b0;
      mem_to_reg  = WB_ALU;
      alu_control = '0;
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
         imm_sel     = dec_imm;
         operand_a   = dec_a;
         operand_b   = dec_b;
         alu_control = dec_alu;
      end
      case (state_q)
         ST_FETCH: begin
            imem_req = !rst;
            ir_write = !rst && imem_ack;
         end
         ST_EXEC: begin
            if (is_branch) begin
               pc_write = 1'b1;
               next_sel = br_taken;
            end
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            pc_write = is_store && dmem_ack;
         end
         ST_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            next_sel  = is_jump;
            if (is_load)      mem_to_reg = WB_MEM;
            else if (is_jump) mem_to_reg = WB_PC4;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: randomized and directed
// instructions, a spec-level expectation model, and trap/reset scenarios.
module tb_multicycle_control_unit;

   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] fun3;
   logic       fun7, br_taken, imem_ack, dmem_ack;
   logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, next_sel, reg_write;
   logic [2:0] imm_sel;
   logic       operand_a, operand_b;
   logic [1:0] mem_to_reg;
   logic [3:0] alu_control;
   logic       illegal, fault;

   always #5 clk = ~clk;

   multicycle_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .fun3(fun3), .fun7(fun7),
      .br_taken(br_taken), .imem_req(imem_req), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .ir_write(ir_write), .pc_write(pc_write), .next_sel(next_sel),
      .reg_write(reg_write), .imm_sel(imm_sel), .operand_a(operand_a),
      .operand_b(operand_b), .mem_to_reg(mem_to_reg), .alu_control(alu_control),
      .illegal(illegal), .fault(fault)
   );

   typedef struct {
      int         lat;       // cycles from ir_write to the closing pc_write
      logic       next_sel;
      logic       reg_write;
      logic [1:0] m2r;
      logic [3:0] alu;
      logic       opa, opb;
      logic [2:0] imm;
      logic       is_mem, we;
      int         mem_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   localparam logic [6:0] LOAD = 7'b0000011, OPI = 7'b0010011, AUIPC = 7'b0010111,
                          STORE = 7'b0100011, OPR = 7'b0110011, LUI = 7'b0110111,
                          BR = 7'b1100011, JALR = 7'b1100111, JAL = 7'b1101111;
   logic [6:0] legal_ops [9] = '{LOAD, OPI, AUIPC, STORE, OPR, LUI, BR, JALR, JAL};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal_op(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Expected behaviour of one instruction, taken from the instruction-class rules.
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic bt, input int dd);
      exp_t e;
      int arith [8];
      arith = '{0, 2, 3, 4, 5, 6, 8, 9};   // ADD SLL SLT SLTU XOR SRL OR AND
      e.lat = 3; e.next_sel = 0; e.reg_write = 1; e.m2r = 0; e.alu = 0;
      e.opa = 0; e.opb = 0; e.imm = 0; e.is_mem = 0; e.we = 0; e.mem_cyc = 0;
      if (op == OPR || op == OPI) begin
         e.alu = 4'(arith[f3]);
         if (f7 && f3 == 3'd5) e.alu = 4'd7;
         if (f7 && f3 == 3'd0 && op == OPR) e.alu = 4'd1;
         e.opb = (op == OPI);
      end else if (op == LOAD) begin
         e.opb = 1; e.lat = 4 + dd; e.m2r = 1; e.is_mem = 1; e.mem_cyc = dd + 1;
      end else if (op == STORE) begin
         e.imm = 1; e.opb = 1; e.lat = 3 + dd; e.reg_write = 0;
         e.is_mem = 1; e.we = 1; e.mem_cyc = dd + 1;
      end else if (op == BR) begin
         e.imm = 2; e.opa = 1; e.opb = 1; e.lat = 2; e.reg_write = 0; e.next_sel = bt;
      end else if (op == LUI) begin
         e.imm = 3; e.opb = 1; e.alu = 4'd10;
      end else if (op == AUIPC) begin
         e.imm = 3; e.opa = 1; e.opb = 1;
      end else if (op == JAL) begin
         e.imm = 4; e.opa = 1; e.opb = 1; e.next_sel = 1; e.m2r = 2;
      end else begin  // JALR
         e.opb = 1; e.next_sel = 1; e.m2r = 2;
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_imem(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (imem_req) begin ok = 1; return; end
         step();
      end
   endtask

   task automatic wait_dmem(output bit ok);
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         if (dmem_req) begin ok = 1; return; end
         step();
      end
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic bt, input int di, input int dd);
      bit ok;
      wait_imem(ok);
      if (!ok) begin chk("imem_req_wait", 0, 1); return; end
      br_taken = bt;
      for (int i = 0; i < di; i++) begin
         imem_ack = 0; dmem_ack = 1'($urandom); opcode = 7'($urandom);
         step();
      end
      opcode = op; fun3 = f3; fun7 = f7; imem_ack = 1; dmem_ack = 0;
      if (is_legal_op(op)) sb.push_back(model(op, f3, f7, bt, dd));
      step();
      imem_ack = 0; opcode = 7'($urandom); fun3 = 3'($urandom); fun7 = 1'($urandom);
      if (op == LOAD || op == STORE) begin
         wait_dmem(ok);
         if (!ok) begin chk("dmem_req_wait", 0, 1); return; end
         for (int i = 0; i < dd; i++) step();
         dmem_ack = 1;
         step();
         dmem_ack = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      rst = 0;
   endtask

   // Monitor: pops one expectation per completed instruction (its closing pc_write).
   initial begin : monitor
      int   cyc, mcyc;
      logic mwe;
      exp_t e;
      cyc = 0; mcyc = 0; mwe = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc = 0; mcyc = 0;
         end else begin
            if (ir_write) begin cyc = 0; mcyc = 0; end
            else cyc++;
            if (dmem_req) begin mcyc++; mwe = dmem_we; end
            if (reg_write && !pc_write) chk("reg_write_without_pc_write", 1, 0);
            if (pc_write) begin
               if (sb.size() == 0) chk("unexpected_pc_write", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("latency", cyc, e.lat);
                  chk("next_sel", next_sel, e.next_sel);
                  chk("reg_write", reg_write, e.reg_write);
                  chk("mem_to_reg", mem_to_reg, e.m2r);
                  chk("alu_control", alu_control, e.alu);
                  chk("operand_a", operand_a, e.opa);
                  chk("operand_b", operand_b, e.opb);
                  chk("imm_sel", imm_sel, e.imm);
                  chk("dmem_cycles", mcyc, e.mem_cyc);
                  if (e.is_mem) chk("dmem_we", mwe, e.we);
               end
            end
         end
      end
   end

   initial begin : stim
      bit ok;
      int n;
      rst = 1; opcode = 0; fun3 = 0; fun7 = 0; br_taken = 0; imem_ack = 0; dmem_ack = 0;
      step(); step();
      chk("reset_outputs", {imem_req, dmem_req, ir_write, pc_write, reg_write, illegal, fault}, 0);
      rst = 0;
      #1;
      chk("imem_req_after_reset", imem_req, 1);
      chk("flags_after_reset", {illegal, fault, dmem_req}, 0);

      issue(OPR, 3'd0, 1'b0, 1'b0, 0, 0);   // ADD, ack in first FETCH cycle
      issue(LOAD, 3'd2, 1'b0, 1'b0, 0, 3);  // LW, dmem_ack 3 cycles late
      issue(BR, 3'd0, 1'b0, 1'b1, 0, 0);    // BEQ taken
      issue(BR, 3'd0, 1'b0, 1'b0, 1, 0);    // BEQ not taken
      issue(OPR, 3'd0, 1'b1, 1'b0, 2, 0);   // SUB
      issue(OPI, 3'd5, 1'b1, 1'b0, 0, 0);   // SRAI
      issue(OPI, 3'd0, 1'b1, 1'b0, 0, 0);   // ADDI with instr[30] set stays ADD
      issue(LUI, 3'd0, 1'b0, 1'b0, 0, 0);
      issue(JAL, 3'd0, 1'b0, 1'b0, 0, 0);
      issue(OPR, 3'd7, 1'b0, 1'b0, TO - 1, 0);   // fetch ack on the last allowed cycle
      issue(LOAD, 3'd2, 1'b0, 1'b0, 0, TO - 1);  // data ack on the last allowed cycle
      issue(STORE, 3'd2, 1'b0, 1'b0, 0, 2);

      for (int i = 0; i < 60; i++)
         issue(legal_ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      wait_imem(ok);
      chk("scoreboard_drained", sb.size(), 0);

      // Undefined opcode traps with no strobes and ignores further acks.
      issue(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0);
      step();
      chk("illegal_set", {illegal, fault}, 2'b10);
      imem_ack = 1; dmem_ack = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("trap_no_strobes", {imem_req, dmem_req, ir_write, pc_write, reg_write}, 0);
      end
      imem_ack = 0; dmem_ack = 0;
      chk("illegal_sticky", illegal, 1);
      do_reset();
      #1;
      chk("illegal_cleared_by_reset", {illegal, imem_req}, 2'b01);

      // Fetch never acknowledged: fault after exactly TO request cycles.
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!imem_req) break;
         n++;
         step();
      end
      chk("timeout_req_cycles", n, TO);
      chk("fault_set", {fault, imem_req, illegal}, 3'b100);
      imem_ack = 1;
      repeat (3) step();
      chk("fault_held", {fault, imem_req, ir_write}, 3'b100);
      imem_ack = 0;
      do_reset();
      #1;
      chk("fault_cleared_by_reset", {fault, imem_req}, 2'b01);

      // Reset in the middle of a store's MEM wait.
      wait_imem(ok);
      opcode = STORE; fun3 = 3'd2; fun7 = 0; imem_ack = 1;
      step();
      imem_ack = 0;
      wait_dmem(ok);
      chk("sw_reached_mem", dmem_req, ok ? 1'b1 : 1'b0);
      step(); step();
      #2 rst = 1;
      #1;
      chk("dmem_req_drops_on_reset", {dmem_req, pc_write, imem_req}, 0);
      step();
      rst = 0;
      #1;
      chk("restart_in_fetch", imem_req, 1);
      issue(OPR, 3'd6, 1'b0, 1'b0, 0, 0);
      wait_imem(ok);
      chk("scoreboard_drained_end", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
